multdiv_sequencer: RTL
======================

Name: multdiv_sequencer

Overview:
Iterative signed multiply/divide unit for the execute stage of the 5-stage pipeline. It accepts one-cycle start pulses for MULT/DIV and runs a 32-iteration radix-2 Booth multiply or a restoring divide. It drives `mult_operation_underway` and `div_operation_underway`, which decode uses to hold the F/D latch. It returns a 32-bit result, an exception flag and a one-cycle ready strobe for the X/M latch and the rstatus logic.

Parameters:
- WIDTH, 32: operand and result width.
- ITER, 32: iteration cycles per operation; must equal WIDTH.
- CNT_W, 5: iteration counter width, equal to clog2(ITER).

Ports:
- clock  in  1  master clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- ctrl_MULT  in  1  start-multiply pulse, sampled only in IDLE
- ctrl_DIV  in  1  start-divide pulse, sampled only in IDLE
- operand_A  in  WIDTH  multiplicand / dividend, captured on start
- operand_B  in  WIDTH  multiplier / divisor, captured on start
- result  out  WIDTH  product low word or quotient; held until next start
- exception  out  1  overflow or divide-by-zero; held with result
- result_ready  out  1  one-cycle strobe, result valid
- mult_operation_underway  out  1  multiply busy (stall request)
- div_operation_underway  out  1  divide busy (stall request)

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE, counter 0, result 0, exception 0, result_ready 0. Applies mid-operation; the operation is aborted, with no ready strobe and no partial result.
- States and transitions:
  - IDLE: ctrl_MULT → MULT; else ctrl_DIV → DIV; else stay.
  - MULT / DIV: counter increments each cycle; at count ITER-1 → DONE.
  - DONE: lasts one cycle; result_ready=1; → IDLE.
- ctrl_MULT and ctrl_DIV both high in IDLE: treated as MULT, DIV ignored.
- Start pulses outside IDLE are ignored, with no queueing. Operands are latched at start, so later changes on operand_A/B have no effect.
- Busy outputs are combinational:
  - mult_operation_underway = (state==MULT) | (state==IDLE & ctrl_MULT).
  - div_operation_underway = (state==DIV) | (state==IDLE & ctrl_DIV & ~ctrl_MULT).
  - The stall therefore asserts in the start cycle. It is low in DONE so the pipeline advances with the result.
- Latency: start sampled at edge k; busy high in cycles k..k+32; result_ready=1 in cycle k+33. This is fixed at 34 cycles, except as noted under Optional Feature.
- Multiply:
  - 65-bit Booth register {A(33), Q(32)} plus a Q-1 bit, arithmetic shift right each iteration.
  - result = product[31:0].
  - exception = product[63:31] not all-equal (signed 32-bit overflow).
- Divide:
  - Operate on magnitudes with a restoring step per iteration.
  - Quotient is negated if the operand signs differ, truncating toward zero. The remainder is discarded.
  - Divisor 0: result 0, exception 1; latency unchanged.
  - 0x80000000 / -1: result 0x80000000, exception 1.
- result and exception update only on entry to DONE and persist through IDLE until the next DONE.

Optional Feature:
- Macro: MULTDIV_EARLY_TERM_EN.
- Defined: a zero operand on a multiply, or a zero divisor on a divide, goes IDLE → DONE directly. Busy is high only in the start cycle and result_ready appears at k+1. Result and exception values are identical to the full-length case.
- Undefined: all operations take the fixed 34-cycle latency.

Decomposition:
- Package multdiv_pkg holds:
  - the state encoding (IDLE=2'd0, MULT=2'd1, DIV=2'd2, DONE=2'd3);
  - ITER, CNT_W and WIDTH constants;
  - INT_MIN = 32'h8000_0000.
- One sub-module, iter_counter: CNT_W-bit counter with synchronous clear, enable and terminal-count output. The sequencer instantiates it once.

Test Plan:
- MULT 7 × -6 pulsed at cycle 0 → mult_operation_underway high cycles 0–32; result_ready at cycle 33; result 0xFFFFFFD6 (-42); exception 0.
- MULT 0x00010000 × 0x00010000 → result 0x00000000, exception 1 at cycle 33.
- DIV -100 / 7 → result 0xFFFFFFF2 (-14), exception 0. DIV 5 / 0 → result 0, exception 1, same latency; with MULTDIV_EARLY_TERM_EN, ready at cycle 1.
- DIV INT_MIN / -1 → result 0x80000000, exception 1. ctrl_DIV pulsed at cycle 10 of a MULT → ignored, and div_operation_underway stays 0.
- Start MULT, drive reset=0 at cycle 15 → next cycle busy 0, result 0, exception 0, no result_ready. A new MULT after reset completes normally in 34 cycles.
- ctrl_MULT and ctrl_DIV both high in IDLE → multiply performed; only mult_operation_underway asserts.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared constants and state encoding for the iterative multiply/divide
// sequencer and its iteration counter.
package multdiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = 5;

    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : multdiv_pkg

// File: rtl/multdiv_sequencer_iter_counter.sv
// Iteration counter: CNT_W-bit up-counter with synchronous clear, count
// enable and a terminal-count flag raised on the final iteration.
module iter_counter #(
    parameter int CNT_W = multdiv_pkg::CNT_W,
    parameter int ITER  = multdiv_pkg::ITER
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(ITER - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Count iterations; clear takes priority over enable.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_en) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule : iter_counter

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) sequencer.
// Busy outputs stall decode from the start cycle until the result is ready.
// Optional build macro: MULTDIV_EARLY_TERM_EN -- when defined, a multiply
// with a zero operand or a divide by zero skips straight to DONE.
module multdiv_sequencer #(
    parameter int WIDTH = multdiv_pkg::WIDTH,
    parameter int ITER  = multdiv_pkg::ITER,
    parameter int CNT_W = multdiv_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_ready,
    output logic             mult_operation_underway,
    output logic             div_operation_underway
);

    import multdiv_pkg::*;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

    // Two's-complement magnitude; the most negative value maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + ONE_W) : v;
    endfunction

    state_t r_state;
    state_t w_state_nx;

    logic w_start_mult;
    logic w_start_div;
    logic w_early;
    logic w_early_exc;
    logic w_tc;
    logic w_cnt_en;

    // Datapath: Booth uses {acc, q, q1} with m = multiplicand; divide uses
    // acc as partial remainder, q as dividend/quotient, m as divisor.
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic [WIDTH:0]   r_m;
    logic             r_neg;
    logic             r_dz;
    logic             r_ovf;
    logic [WIDTH-1:0] r_result;
    logic             r_exc;
    logic             r_ready;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_acc_nx;
    logic [WIDTH-1:0]   w_q_nx;
    logic               w_q1_nx;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH:0]     w_prod_hi;
    logic               w_mult_ovf;
    logic [WIDTH-1:0]   w_quot;

    assign w_start_mult = (r_state == ST_IDLE) & ctrl_MULT;
    assign w_start_div  = (r_state == ST_IDLE) & ctrl_DIV & ~ctrl_MULT;
    assign w_cnt_en     = (r_state == ST_MULT) | (r_state == ST_DIV);

`ifdef MULTDIV_EARLY_TERM_EN
    assign w_early     = (w_start_mult & ((operand_A == ZERO_W) | (operand_B == ZERO_W)))
                       | (w_start_div & (operand_B == ZERO_W));
    assign w_early_exc = w_start_div;
`else
    assign w_early     = 1'b0;
    assign w_early_exc = 1'b0;
`endif

    iter_counter #(
        .CNT_W (CNT_W),
        .ITER  (ITER)
    ) u_iter_counter (
        .clock (clock),
        .reset (reset),
        .i_clr (~w_cnt_en),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic; MULT wins when both starts are high.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_early) begin
                    w_state_nx = ST_DONE;
                end else if (w_start_mult) begin
                    w_state_nx = ST_MULT;
                end else if (w_start_div) begin
                    w_state_nx = ST_DIV;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_MULT: begin
                if (w_tc) begin
                    w_state_nx = ST_DONE;
                end else begin
                    w_state_nx = ST_MULT;
                end
            end
            ST_DIV: begin
                if (w_tc) begin
                    w_state_nx = ST_DONE;
                end else begin
                    w_state_nx = ST_DIV;
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Busy outputs: asserted already in the start cycle, low in DONE.
    always_comb begin
        mult_operation_underway = 1'b0;
        div_operation_underway  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                mult_operation_underway = ctrl_MULT;
                div_operation_underway  = ctrl_DIV & ~ctrl_MULT;
            end
            ST_MULT: mult_operation_underway = 1'b1;
            ST_DIV:  div_operation_underway  = 1'b1;
            default: begin
                mult_operation_underway = 1'b0;
                div_operation_underway  = 1'b0;
            end
        endcase
    end

    // One iteration step of the active algorithm.
    always_comb begin
        w_sum    = r_acc;
        w_rem_sh = r_acc;
        w_trial  = r_acc;
        w_acc_nx = r_acc;
        w_q_nx   = r_q;
        w_q1_nx  = r_q1;
        if (r_state == ST_MULT) begin
            case ({r_q[0], r_q1})
                2'b01:   w_sum = r_acc + r_m;
                2'b10:   w_sum = r_acc - r_m;
                default: w_sum = r_acc;
            endcase
            {w_acc_nx, w_q_nx, w_q1_nx} = {w_sum[WIDTH], w_sum, r_q};
        end else if (r_state == ST_DIV) begin
            w_rem_sh = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
            w_trial  = w_rem_sh - r_m;
            if (!w_trial[WIDTH]) begin
                w_acc_nx = w_trial;
                w_q_nx   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nx = w_rem_sh;
                w_q_nx   = {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_nx = r_acc;
            w_q_nx   = r_q;
        end
    end

    // Final-iteration result forms: product overflow check and signed quotient.
    assign w_product  = {w_acc_nx[WIDTH-1:0], w_q_nx};
    assign w_prod_hi  = w_product[2*WIDTH-1:WIDTH-1];
    assign w_mult_ovf = ~((&w_prod_hi) | ~(|w_prod_hi));
    assign w_quot     = r_neg ? (~w_q_nx + ONE_W) : w_q_nx;

    // Operand capture, iteration registers and result/exception hold.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_acc    <= {(WIDTH+1){1'b0}};
            r_q      <= ZERO_W;
            r_q1     <= 1'b0;
            r_m      <= {(WIDTH+1){1'b0}};
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= ZERO_W;
            r_exc    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_early) begin
                        r_result <= ZERO_W;
                        r_exc    <= w_early_exc;
                    end else if (w_start_mult) begin
                        r_acc <= {(WIDTH+1){1'b0}};
                        r_q   <= operand_B;
                        r_q1  <= 1'b0;
                        r_m   <= {operand_A[WIDTH-1], operand_A};
                    end else if (w_start_div) begin
                        r_acc <= {(WIDTH+1){1'b0}};
                        r_q   <= magnitude(operand_A);
                        r_q1  <= 1'b0;
                        r_m   <= {1'b0, magnitude(operand_B)};
                        r_neg <= operand_A[WIDTH-1] ^ operand_B[WIDTH-1];
                        r_dz  <= (operand_B == ZERO_W);
                        r_ovf <= (operand_A == INT_MIN) & (operand_B == ONES_W);
                    end else begin
                        r_acc <= r_acc;
                    end
                end
                ST_MULT: begin
                    r_acc <= w_acc_nx;
                    r_q   <= w_q_nx;
                    r_q1  <= w_q1_nx;
                    if (w_tc) begin
                        r_result <= w_product[WIDTH-1:0];
                        r_exc    <= w_mult_ovf;
                    end else begin
                        r_result <= r_result;
                    end
                end
                ST_DIV: begin
                    r_acc <= w_acc_nx;
                    r_q   <= w_q_nx;
                    if (w_tc) begin
                        r_result <= r_dz ? ZERO_W : w_quot;
                        r_exc    <= r_dz | r_ovf;
                    end else begin
                        r_result <= r_result;
                    end
                end
                default: begin
                    r_result <= r_result;
                end
            endcase
        end
    end

    // Ready strobe is registered and high exactly while in DONE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_state_nx == ST_DONE);
        end
    end

    assign result       = r_result;
    assign exception    = r_exc;
    assign result_ready = r_ready;

endmodule : multdiv_sequencer
